// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: one-entry sample-pair buffer feeding an MSB-first,
// one-bit-delayed I2S stream. Define I2S_TX_UNDERRUN_CNT_EN to add underrun_cnt_o.
module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  bclk_i,
  input  logic                  lrclk_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] right_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sd_o,
  output logic                  underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt_o
`endif
);

  localparam int KW = $clog2(SLOT_WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(SLOT_WIDTH - 1);
  localparam logic [KW-1:0] K_DATA = KW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t                state, state_next;
  logic                  bclk_q, lrclk_q;
  logic                  fall, lr_edge;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_left, buf_right;
  logic [DATA_WIDTH-1:0] frame_left, frame_right;
  logic [DATA_WIDTH-1:0] shift;
  logic [KW-1:0]         k;
  logic                  accept, load, slot_start, bit_step, underrun_set;

  assign fall         = bclk_q & ~bclk_i;
  assign lr_edge      = fall & (lrclk_i != lrclk_q);
  assign ready_o      = ~buf_full;
  assign accept       = enable_i & valid_i & ~buf_full;
  assign underrun_set = load & ~buf_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    slot_start = 1'b0;
    bit_step   = 1'b0;
    if (!enable_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = SYNC;
        SYNC: begin
          if (lr_edge && !lrclk_i) begin
            load       = 1'b1;
            slot_start = 1'b1;
            state_next = RUN;
          end
        end
        RUN: begin
          if (lr_edge) begin
            slot_start = 1'b1;
            load       = ~lrclk_i;
          end else if (fall) begin
            bit_step = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b1;
      buf_full    <= 1'b0;
      buf_left    <= '0;
      buf_right   <= '0;
      frame_left  <= '0;
      frame_right <= '0;
      shift       <= '0;
      k           <= '0;
      sd_o        <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      bclk_q     <= bclk_i;
      underrun_o <= underrun_set;
      if (fall) lrclk_q <= lrclk_i;
      if (!enable_i) begin
        buf_full    <= 1'b0;
        frame_left  <= '0;
        frame_right <= '0;
        shift       <= '0;
        k           <= '0;
        sd_o        <= 1'b0;
      end else begin
        // A load and an accept never coincide with a full buffer, so the
        // pair accepted alongside an underrun load waits for the next frame.
        if (accept) begin
          buf_left  <= left_i;
          buf_right <= right_i;
          buf_full  <= 1'b1;
        end else if (load) begin
          buf_full <= 1'b0;
        end
        if (load) begin
          frame_left  <= buf_full ? buf_left  : '0;
          frame_right <= buf_full ? buf_right : '0;
        end
        if (slot_start) begin
          k    <= '0;
          sd_o <= 1'b0;
          shift <= lrclk_i ? frame_right : (buf_full ? buf_left : '0);
        end else if (bit_step) begin
          if (k != K_LAST) k <= k + 1'b1;
          sd_o  <= shift[DATA_WIDTH-1] & (k < K_DATA);
          shift <= shift << 1;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    underrun_cnt_o <= '0;
    else if (!enable_i)                             underrun_cnt_o <= '0;
    else if (underrun_set && underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: built-in divide-by-14, 64-BCLK generator, per-cycle
// expectation queue and a per-frame serial-word scoreboard.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        bclk_i = 1'b0;
  logic        lrclk_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [23:0] left_i = '0;
  logic [23:0] right_i = '0;
  logic        ready_o, sd_o, underrun_o;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  i2s_tx_serializer #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .bclk_i(bclk_i), .lrclk_i(lrclk_i),
    .left_i(left_i), .right_i(right_i), .valid_i(valid_i), .ready_o(ready_o),
    .sd_o(sd_o), .underrun_o(underrun_o)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt_o(underrun_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sd; logic under; logic ready; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] frame_q[$];

  int n_checks = 0, n_fail = 0, cyc = 0, frame_no = 0;
  int gen_cnt, bitcnt, cap_n, accepts, m_state, m_k;
  logic [63:0] cap;
  logic m_bclk_q, m_lrclk_q, m_full, m_sd, auto_data, hs_mode, hs_started;
  logic [23:0] m_bl, m_br, m_fl, m_fr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_bclk_q = 0; m_lrclk_q = 1; m_state = 0; m_full = 0; m_k = 0; m_sd = 0;
    m_bl = 0; m_br = 0; m_fl = 0; m_fr = 0;
    gen_cnt = 0; bitcnt = 63; bclk_i = 0; lrclk_i = 1;
    frame_q.delete(); exp_q.delete(); cap_n = 0;
  endtask

  task automatic cycle();
    logic fall, lre, load, acc, u, sd_n, full_n;
    int st_n, k_n;
    logic [23:0] fl_n, fr_n, bl_n, br_n, ch;
    exp_t e;
    logic [63:0] fe;
    @(negedge clk);
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL cycle_budget: ran %0d cycles, limit 60000", cyc);
      $fatal(1);
    end
    gen_cnt++;
    if (gen_cnt == 7) bclk_i = 1;
    else if (gen_cnt == 14) begin
      gen_cnt = 0; bclk_i = 0; bitcnt = (bitcnt + 1) % 64; lrclk_i = (bitcnt >= 32);
    end
    fall = m_bclk_q & ~bclk_i;
    lre  = fall & (lrclk_i != m_lrclk_q);
    acc  = enable_i & valid_i & ~m_full;
    load = 0; u = 0;
    st_n = m_state; k_n = m_k; sd_n = m_sd; full_n = m_full;
    fl_n = m_fl; fr_n = m_fr; bl_n = m_bl; br_n = m_br;
    if (!enable_i) begin
      st_n = 0; full_n = 0; fl_n = 0; fr_n = 0; k_n = 0; sd_n = 0;
    end else begin
      case (m_state)
        0: st_n = 1;
        1: if (lre && !lrclk_i) begin load = 1; st_n = 2; k_n = 0; sd_n = 0; end
        default: begin
          if (lre) begin load = !lrclk_i; k_n = 0; sd_n = 0; end
          else if (fall) begin
            k_n  = (m_k < 31) ? m_k + 1 : 31;
            ch   = lrclk_i ? m_fr : m_fl;
            sd_n = (k_n <= 24) ? ch[24-k_n] : 1'b0;
          end
        end
      endcase
      if (load) begin
        if (m_full) begin fl_n = m_bl; fr_n = m_br; full_n = 0; end
        else begin fl_n = 0; fr_n = 0; u = 1; end
      end
      if (acc) begin bl_n = left_i; br_n = right_i; full_n = 1; end
    end
    exp_q.push_back('{sd: sd_n, under: u, ready: ~full_n});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("sd", sd_o, e.sd);
    check("underrun", underrun_o, e.under);
    check("ready", ready_o, e.ready);
    if (load) begin
      if (cap_n == 64 && frame_q.size() > 0) begin
        fe = frame_q.pop_front();
        frame_no++;
        $display("frame %0d: sd word %016h expected %016h", frame_no, cap, fe);
        check("frame_word", cap, fe);
      end else frame_q.delete();
      frame_q.push_back({1'b0, fl_n, 7'b0, 1'b0, fr_n, 7'b0});
      cap = {63'b0, sd_o}; cap_n = 1;
    end else if (fall && cap_n > 0 && cap_n < 64) begin
      cap = {cap[62:0], sd_o}; cap_n++;
    end
    if (!enable_i) begin cap_n = 0; frame_q.delete(); end
    if (load && hs_mode) begin
      if (hs_started) check("accepts_per_frame", accepts, 1);
      hs_started = 1; accepts = 0;
    end
    if (acc) accepts++;
    m_bclk_q = bclk_i;
    if (fall) m_lrclk_q = lrclk_i;
    m_state = st_n; m_k = k_n; m_sd = sd_n; m_full = full_n;
    m_fl = fl_n; m_fr = fr_n; m_bl = bl_n; m_br = br_n;
    if (acc) begin
      if (auto_data) begin left_i = left_i + 24'h111111; right_i = right_i - 24'h010101; end
      else valid_i = 0;
    end
  endtask

  task automatic run_until(input int b, input int gc, input int budget);
    int n = 0;
    while (!(bitcnt == b && gen_cnt == gc) && n < budget) begin cycle(); n++; end
    check("wait_in_budget", n < budget, 1'b1);
  endtask

  task automatic run_frames(input int n);
    repeat (n * 896) cycle();
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    left_i = l; right_i = r; valid_i = 1;
  endtask

  initial begin
    auto_data = 0; hs_mode = 0; hs_started = 0; accepts = 0; cap = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_sd", sd_o, 1'b0);
    check("reset_ready", ready_o, 1'b1);
    check("reset_underrun", underrun_o, 1'b0);
    @(negedge clk);
    rst_ni = 1;

    // Basic frame: one pair ahead of the first left slot, then an underrun frame
    enable_i = 1;
    send(24'hA5F00F, 24'h800001);
    run_frames(2);

    // Continuous valid: one accept per frame
    auto_data = 1; hs_mode = 1; hs_started = 0;
    send(24'h102030, 24'h0F0E0D);
    run_frames(4);
    valid_i = 0; auto_data = 0; hs_mode = 0;

    // Underrun: clear via disable, then three empty frames
    run_until(20, 3, 2000);
    enable_i = 0; cycle(); enable_i = 1;
    for (int i = 0; i < 3; i++) begin cycle(); run_until(0, 1, 2000); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt_o, 16'd3);
`endif

    // Late sample: valid in the same clk as the load
    run_until(63, 13, 2000);
    send(24'h123456, 24'hFEDCBA);
    cycle();
    check("late_underrun", underrun_o, 1'b1);
    run_frames(2);

    // Disable at k=10 of the left slot with the buffer full
    run_until(62, 0, 2000);
    send(24'h3C3C3C, 24'hC3C3C3);
    run_until(0, 1, 2000);
    send(24'h777777, 24'h888888);
    run_until(10, 0, 2000);
    enable_i = 0;
    cycle();
    check("disable_sd", sd_o, 1'b0);
    check("disable_ready", ready_o, 1'b1);
    enable_i = 1;
    send(24'hABCDEF, 24'h654321);
    run_frames(3);

    // Async reset at k=5 of the right slot
    run_until(62, 0, 2000);
    send(24'h5A5A5A, 24'hFFFFFF);
    run_until(0, 1, 2000);
    send(24'h111111, 24'h222222);
    run_until(37, 0, 2000);
    check("pre_reset_sd", sd_o, 1'b1);
    check("pre_reset_ready", ready_o, 1'b0);
    #2 rst_ni = 0;
    valid_i = 0;
    #1;
    check("async_reset_sd", sd_o, 1'b0);
    check("async_reset_ready", ready_o, 1'b1);
    check("async_reset_underrun", underrun_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1;
    model_reset();
    send(24'h0055AA, 24'hAA5500);
    run_frames(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
